// File: rtl/regfile_write_bank.sv
// Register-file write bank: 32 x DATA_W storage, busy-bit scoreboard, write pulse/count/error status.
// Optional macro REGFILE_WRITE_BYPASS_EN makes regs_flat/busy show the in-flight write combinationally.
module regfile_write_bank #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    output logic [NREG*DATA_W-1:0] regs_flat,
    output logic [NREG-1:0]        busy,
    output logic [NREG-1:0]        wr_onehot,
    output logic [15:0]            wr_count,
    output logic                   err_unowned
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   wr_onehot_q, wr_onehot_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              err_unowned_q, err_unowned_d;
    logic [NREG-1:0]   dec;
    logic              wr_hit;

    always_comb begin
        dec = '0;
        if (wr_en) dec[wr_addr] = 1'b1;
        wr_hit = wr_en && (wr_addr != '0);

        regs_d        = regs_q;
        busy_d        = busy_q;
        wr_onehot_d   = '0;
        wr_count_d    = wr_count_q;
        err_unowned_d = err_unowned_q;

        if (wr_hit) begin
            regs_d[wr_addr] = wr_data;
            wr_onehot_d     = dec;
            wr_count_d      = wr_count_q + 16'd1;
            busy_d[wr_addr] = 1'b0;
            if (!busy_q[wr_addr]) err_unowned_d = 1'b1;
        end
        // A set applied after the clear lets a new producer keep ownership.
        if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;

        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            busy_q        <= '0;
            wr_onehot_q   <= '0;
            wr_count_q    <= '0;
            err_unowned_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
            busy_q        <= busy_d;
            wr_onehot_q   <= wr_onehot_d;
            wr_count_q    <= wr_count_d;
            err_unowned_q <= err_unowned_d;
        end
    end

`ifdef REGFILE_WRITE_BYPASS_EN
    // Reset also suppresses the write-through so outputs read zero while reset is held.
    logic byp;
    assign byp = wr_hit && reset_n;
`endif

    for (genvar gi = 0; gi < NREG; gi++) begin : g_out
`ifdef REGFILE_WRITE_BYPASS_EN
        logic sel;
        assign sel = byp && (wr_addr == ADDR_W'(gi));
        assign regs_flat[gi*DATA_W +: DATA_W] = sel ? wr_data : regs_q[gi];
        assign busy[gi] = busy_q[gi] &&
                          !(sel && !(set_en && (set_addr == ADDR_W'(gi))));
`else
        assign regs_flat[gi*DATA_W +: DATA_W] = regs_q[gi];
        assign busy[gi] = busy_q[gi];
`endif
    end

    assign wr_onehot   = wr_onehot_q;
    assign wr_count    = wr_count_q;
    assign err_unowned = err_unowned_q;

endmodule

// File: tb/tb_regfile_write_bank.sv
// Self-checking bench for regfile_write_bank: directed cases then random traffic against a reference model.
module tb_regfile_write_bank;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [4:0]    wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic          set_en = 1'b0;
    logic [4:0]    set_addr = '0;
    logic [1023:0] regs_flat;
    logic [31:0]   busy;
    logic [31:0]   wr_onehot;
    logic [15:0]   wr_count;
    logic          err_unowned;

    int total = 0;
    int bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [31:0] m_oh;
    logic [15:0] m_cnt;
    logic        m_err;

    regfile_write_bank dut (
        .clk(clk), .reset_n(reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .set_en(set_en), .set_addr(set_addr),
        .regs_flat(regs_flat), .busy(busy), .wr_onehot(wr_onehot),
        .wr_count(wr_count), .err_unowned(err_unowned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_flat(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy = '0; m_oh = '0; m_cnt = '0; m_err = 1'b0;
    endtask

    // Compare every output against the model, adding the same-cycle view of a live write when bypass is built in.
    task automatic check_all(input string tag);
        logic [1023:0] ef;
        logic [31:0]   eb;
        for (int i = 0; i < 32; i++) ef[i*32 +: 32] = m_regs[i];
        eb = m_busy;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (reset_n && wr_en && wr_addr != 0) begin
            ef[int'(wr_addr)*32 +: 32] = wr_data;
            if (!(set_en && set_addr == wr_addr)) eb[wr_addr] = 1'b0;
        end
`endif
        chk_flat({tag, "_flat"}, regs_flat, ef);
        chk({tag, "_busy"}, busy, eb);
        chk({tag, "_onehot"}, wr_onehot, m_oh);
        chk({tag, "_count"}, 32'(wr_count), 32'(m_cnt));
        chk({tag, "_err"}, 32'(err_unowned), 32'(m_err));
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic se, input logic [4:0] sa);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd; set_en = se; set_addr = sa;
        #1 check_all("pre");
        @(posedge clk);
        if (we && wa != 0) begin
            if (!m_busy[wa]) m_err = 1'b1;
            m_regs[wa] = wd;
            m_busy[wa] = 1'b0;
            m_oh = 32'd1 << wa;
            m_cnt = m_cnt + 16'd1;
        end else begin
            m_oh = '0;
        end
        if (se && sa != 0) m_busy[sa] = 1'b1;
        #1 check_all("post");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1 check_all("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        wr_en = 0; set_en = 0;
        #2 check_all("por");
        do_reset();

        step(0, 0, 0, 1, 5);
        chk("busy5_set", 32'(busy[5]), 32'd1);
        step(1, 5, 32'hDEADBEEF, 0, 0);
        chk("reg5", regs_flat[5*32 +: 32], 32'hDEADBEEF);
        chk("onehot5", wr_onehot, 32'h20);
        chk("count1", 32'(wr_count), 32'd1);
        chk("err0", 32'(err_unowned), 32'd0);
        step(0, 0, 0, 0, 0);
        chk("onehot_pulse", wr_onehot, 32'h0);

        step(1, 0, 32'hFFFFFFFF, 0, 0);
        chk("reg0", regs_flat[31:0], 32'h0);
        chk("count_r0", 32'(wr_count), 32'd1);

        step(0, 0, 0, 1, 9);
        step(1, 9, 32'h12345678, 1, 9);
        chk("reg9", regs_flat[9*32 +: 32], 32'h12345678);
        chk("busy9_kept", 32'(busy[9]), 32'd1);
        chk("err_still0", 32'(err_unowned), 32'd0);

        step(1, 3, 32'h0BADF00D, 0, 0);
        chk("err_unowned", 32'(err_unowned), 32'd1);
        step(1, 9, 32'h55AA55AA, 0, 0);
        chk("err_sticky", 32'(err_unowned), 32'd1);

        step(0, 0, 0, 1, 31);
        step(1, 31, 32'hA5A5A5A5, 0, 0);
        chk("reg31", regs_flat[1023:992], 32'hA5A5A5A5);

        step(0, 0, 0, 1, 0);
        chk("busy0", 32'(busy[0]), 32'd0);

        do_reset();
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        // Asynchronous reset mid-cycle with a write and a set pending at the next edge.
        @(negedge clk);
        wr_en = 1; wr_addr = 7; wr_data = 32'hCAFEF00D; set_en = 1; set_addr = 12;
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        @(posedge clk);
        #1 check_all("rst_hold");
        @(negedge clk);
        wr_en = 0; set_en = 0;
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_bank.md
Name: regfile_write_bank

Overview:
- Write side of the general-purpose register file; the counterpart of the 32:1 read-select muxes in the decode stage.
- Decodes the 5-bit writeback destination into a one-hot enable and stores data into 32 x 32-bit registers; R0 is hardwired to zero.
- Holds a busy-bit scoreboard: issue marks a destination pending, writeback clears it.
- Exports all register contents flattened to feed the read muxes, plus busy bits for hazard detection.

Parameters:
- DATA_W, 32, register width in bits.
- NREG, 32, register count; must equal 2**ADDR_W.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  writeback commit strobe.
- wr_addr  input  ADDR_W  writeback destination.
- wr_data  input  DATA_W  writeback value.
- set_en  input  1  issue strobe; marks set_addr busy.
- set_addr  input  ADDR_W  destination of the issuing instruction.
- regs_flat  output  NREG*DATA_W  register i at bits [i*DATA_W +: DATA_W].
- busy  output  NREG  per-register pending-write bits.
- wr_onehot  output  NREG  registered one-hot of the last accepted write; 1-cycle pulse.
- wr_count  output  16  committed nonzero-destination writes, wraps at 16'hFFFF->0.
- err_unowned  output  1  sticky; a write hit a register whose busy bit was 0.

Behaviour:
- Reset, asynchronous on reset_n low:
  - all registers 0, busy 0, wr_onehot 0, wr_count 0, err_unowned 0.
  - Reset asserted mid-operation discards any same-cycle write or set.
  - Release is synchronous to the next clk edge.
- Decode: one-hot dec[i] = wr_en && (wr_addr == i). Purely combinational internally; outputs are registered.
- Write, at the clk edge when wr_en=1 and wr_addr!=0:
  - reg[wr_addr] <= wr_data.
  - wr_onehot <= dec.
  - wr_count <= wr_count+1.
  - busy[wr_addr] cleared unless overridden by a set (see below).
  - If busy[wr_addr] was 0 before the edge, err_unowned <= 1.
- Write to R0: wr_en=1, wr_addr=0.
  - No storage change, no count, no error.
  - wr_onehot <= 0.
  - reg0 and busy[0] are constant 0.
- No write (wr_en=0): wr_onehot <= 0 at that edge; pulse lasts exactly one cycle.
- Set, at the clk edge when set_en=1 and set_addr!=0: busy[set_addr] <= 1. Set to R0 is ignored.
- Simultaneous write and set, same nonzero address:
  - Data is written and counted.
  - busy stays 1, because the new producer owns the register.
  - err_unowned evaluates the pre-edge busy value.
- Simultaneous write and set, different addresses: both take effect independently.
- Set on an already-busy register: stays 1; no error.
- Latency:
  - Written data is visible on regs_flat one cycle after the write edge.
  - busy updates in the same edge.
  - Without the optional feature there is no write-through.
- wr_count wraps silently.
- err_unowned clears only on reset.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: regs_flat is combinational. Slot wr_addr shows wr_data in the same cycle that wr_en=1 and wr_addr!=0, and all other slots show stored values. busy[wr_addr] reads 0 combinationally in that cycle unless set_en targets the same address.
- Undefined: regs_flat and busy are driven purely from flops, with 1-cycle write visibility as described above.

Test Plan:
- Reset with reset_n=0 asynchronously mid-cycle after prior writes -> regs_flat all 0, busy 0, wr_count 0, err_unowned 0 before the next edge.
- set_en, set_addr=5; next cycle wr_en, wr_addr=5, wr_data=32'hDEADBEEF -> busy[5] 1 then 0; reg5=DEADBEEF; wr_onehot=32'h20 for one cycle; wr_count=1; err_unowned 0.
- wr_en, wr_addr=0, wr_data=32'hFFFFFFFF -> reg0 stays 0, wr_onehot 0, wr_count unchanged.
- Same cycle set_en/set_addr=9 and wr_en/wr_addr=9 with busy[9]=1, wr_data=32'h12345678 -> reg9=12345678, busy[9] stays 1, no error.
- wr_en, wr_addr=3 with busy[3]=0 -> reg3 written and err_unowned=1; it stays 1 after further valid writes until reset.
- With REGFILE_WRITE_BYPASS_EN, wr_en, wr_addr=31, wr_data=32'hA5A5A5A5 -> regs_flat[1023:992]=A5A5A5A5 in the same cycle. Without the macro it appears only after the edge.
